io_loopback_sequencer: RTL

Self-test controller for the board's 5-bit single-ended I/O bank, clocked from the buffered 300 MHz oscillator. While idle, out_pins mirrors in_pins (board passthrough). On start, it drives a fixed pattern sequence onto out_pins, samples the externally looped-back in_pins after a settle interval, and accumulates per-bit failure and error-count results for host or ILA readout.

---
 rtl/io_loopback_sequencer_pkg.sv | 37 +++
 rtl/io_loopback_sequencer_sync_2ff.sv | 27 ++
 rtl/io_loopback_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/io_loopback_sequencer_pkg.sv
// Shared types and pattern generator for the I/O bank loopback self-test.
// The pattern order is all-zeros, all-ones, walking one, then walking zero.
package io_loopback_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int unsigned DEF_WIDTH    = 32'd5;
    localparam int unsigned NUM_PATTERNS = 32'd2 * DEF_WIDTH + 32'd2;
    localparam int unsigned MAX_WIDTH    = 32'd32;

    function automatic logic [MAX_WIDTH-1:0] pattern_for(input int unsigned idx,
                                                         input int unsigned width);
        logic [MAX_WIDTH-1:0] pat_v;
        pat_v = '0;
        for (int unsigned b = 32'd0; b < MAX_WIDTH; b++) begin
            if (b >= width) begin
                pat_v[b] = 1'b0;
            end else if (idx == 32'd1) begin
                pat_v[b] = 1'b1;
            end else if ((idx >= 32'd2) && (idx < width + 32'd2)) begin
                pat_v[b] = (b == idx - 32'd2);
            end else if (idx >= width + 32'd2) begin
                pat_v[b] = (b != idx - width - 32'd2);
            end else begin
                pat_v[b] = 1'b0;
            end
        end
        return pat_v;
    endfunction

endpackage

// File: rtl/io_loopback_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, cleared to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability chain: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/io_loopback_sequencer.sv
// I/O bank loopback self-test: passthrough when idle, pattern drive/compare
// with sticky per-bit failure mask and saturating error count when running.
module io_loopback_sequencer
    import io_loopback_pkg::*;
#(
    parameter int WIDTH         = 5,
    parameter int SETTLE_CYCLES = 8,
    parameter int ERR_W         = 8
) (
    input  logic             clk_300,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_pins,
    output logic [WIDTH-1:0] out_pins,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] fail_mask,
    output logic [ERR_W-1:0] err_count
);

    localparam int NPAT  = 2 * WIDTH + 2;
    localparam int IDX_W = $clog2(NPAT);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAT - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_e           state_r;
    logic [IDX_W-1:0] pat_idx_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [WIDTH-1:0] sync_q_s;
    logic [WIDTH-1:0] pattern_s;
    logic [WIDTH-1:0] diff_s;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk_300),
        .rst_n (rst_n),
        .d     (in_pins),
        .q     (sync_q_s)
    );

    // Current pattern and its mismatch against the synchronised loopback.
    always_comb begin
        pattern_s = WIDTH'(pattern_for(32'(pat_idx_r), WIDTH));
        diff_s    = sync_q_s ^ pattern_s;
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk_300 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pat_idx_r  <= '0;
            wait_cnt_r <= '0;
            out_pins   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            err_count  <= '0;
        end else begin
            done <= 1'b0;
            if ((state_r != IDLE) && abort) begin
                // Partial fail_mask/err_count are kept for post-mortem readout.
                state_r <= IDLE;
                busy    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        out_pins <= sync_q_s;
                        if (start && !abort) begin
                            fail_mask <= '0;
                            err_count <= '0;
                            pass      <= 1'b0;
                            pat_idx_r <= '0;
                            busy      <= 1'b1;
                            state_r   <= DRIVE;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DRIVE: begin
                        out_pins   <= pattern_s;
                        wait_cnt_r <= CNT_LOAD;
                        state_r    <= SETTLE;
                    end
                    SETTLE: begin
                        if (wait_cnt_r == '0) begin
                            state_r <= CHECK;
                        end else begin
                            wait_cnt_r <= wait_cnt_r - CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        fail_mask <= fail_mask | diff_s;
                        if ((diff_s != '0) && (err_count != ERR_MAX)) begin
                            err_count <= err_count + ERR_W'(1);
                        end else begin
                            err_count <= err_count;
                        end
                        if (pat_idx_r == LAST_IDX) begin
                            done    <= 1'b1;
                            pass    <= ((fail_mask | diff_s) == '0);
                            state_r <= DONE;
                        end else begin
                            pat_idx_r <= pat_idx_r + IDX_W'(1);
                            state_r   <= DRIVE;
                        end
                    end
                    DONE: begin
                        out_pins <= '0;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
